// File: rtl/alu_div_seq_pkg.sv
// Shared types and constants for the sequential ALU divider.
// Provides the FSM state enum, default datapath width and step-counter width helper.
package alu_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/alu_div_seq_if.sv
// Operand/result handshake between execute (master) and the divider (slave).
interface alu_div_seq_if import alu_pkg::*; #(
    parameter int N = ALU_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic         sgn;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dz;
    logic         ovf;

    modport master (
        output in_valid, sgn, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz, ovf
    );

    modport slave (
        input  in_valid, sgn, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz, ovf
    );

endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the
// divisor magnitude from the (N+1)-bit shifted remainder, select the quotient bit.
module alu_div_step import alu_pkg::*; #(
    parameter int N = ALU_W
) (
    input  logic [N-1:0] rem_in,
    input  logic [N-1:0] q_in,
    input  logic [N-1:0] dvs,
    output logic [N-1:0] rem_out,
    output logic [N-1:0] q_out
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;
    logic         q_bit;

    always_comb begin
        shifted = {rem_in, q_in[N-1]};
        q_bit   = (shifted >= {1'b0, dvs});
        // The kept difference is always below dvs, so the low N bits are exact.
        diff    = shifted[N-1:0] - dvs;
        rem_out = q_bit ? diff : shifted[N-1:0];
        q_out   = {q_in[N-2:0], q_bit};
    end

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define ALU_DIV_SIGNED_EN to build signed mode (sgn input, magnitude/negate fix-up, ovf).
module alu_div_seq import alu_pkg::*; #(
    parameter int N = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_div_seq_if.slave bus
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  rem_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  dvs_reg;
    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          dz_reg;
    logic          ovf_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;

    logic [N-1:0]  dd_mag;
    logic [N-1:0]  dv_mag;
    logic          is_ovf;
    logic [N-1:0]  step_rem;
    logic [N-1:0]  step_q;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;

    alu_div_step #(.N(N)) u_step (
        .rem_in  (rem_reg),
        .q_in    (q_reg),
        .dvs     (dvs_reg),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

`ifdef ALU_DIV_SIGNED_EN
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    logic dd_neg;
    logic dv_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    always_comb begin
        dd_neg = bus.sgn & bus.dividend[N-1];
        dv_neg = bus.sgn & bus.divisor[N-1];
        dd_mag = dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        dv_mag = dv_neg ? (~bus.divisor + 1'b1) : bus.divisor;
        is_ovf = bus.sgn && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
        // Sign fix-up folds into the final output load, so it costs no cycle.
        q_fin  = neg_q_reg ? (~step_q + 1'b1) : step_q;
        r_fin  = neg_r_reg ? (~step_rem + 1'b1) : step_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (state_reg == IDLE && bus.in_valid) begin
            neg_q_reg <= dd_neg ^ dv_neg;
            neg_r_reg <= dd_neg;
        end
    end
`else
    logic sgn_unused;

    always_comb begin
        sgn_unused = bus.sgn;
        dd_mag     = bus.dividend;
        dv_mag     = bus.divisor;
        is_ovf     = 1'b0;
        q_fin      = step_q;
        r_fin      = step_rem;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            dvs_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        cnt_reg      <= '0;
                        if (bus.divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dz_reg        <= 1'b1;
                            ovf_reg       <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else if (is_ovf) begin
                            quotient_reg  <= bus.dividend;
                            remainder_reg <= '0;
                            dz_reg        <= 1'b0;
                            ovf_reg       <= 1'b1;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            rem_reg   <= '0;
                            q_reg     <= dd_mag;
                            dvs_reg   <= dv_mag;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= step_rem;
                    q_reg   <= step_q;
                    if (cnt_reg == LAST) begin
                        quotient_reg  <= q_fin;
                        remainder_reg <= r_fin;
                        dz_reg        <= 1'b0;
                        ovf_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.dz        = dz_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: unsigned/signed divides, divide-by-zero,
// signed overflow, backpressure and mid-RUN reset, with hand-computed results.
module tb_alu_div_seq;
    import alu_pkg::*;

    localparam int N = 64;
    localparam logic [N-1:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [N-1:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [N-1:0] M100    = -64'sd100;
    localparam logic [N-1:0] M7      = -64'sd7;
    localparam logic [N-1:0] M14     = -64'sd14;
    localparam logic [N-1:0] M2      = -64'sd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_div_seq_if #(.N(N)) bus ();

    alu_div_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        check("in_ready_before_send", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.sgn      = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after the acceptance edge until out_valid is seen high.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_take", {63'd0, bus.in_ready}, 64'd1);
        check("out_valid_after_take", {63'd0, bus.out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] eq,
                          input logic [N-1:0] er, input logic edz, input logic eovf,
                          input int elat);
        int lat;
        send(s, a, b);
        wait_valid(lat);
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"}, bus.quotient, eq);
        check({tag, ".r"}, bus.remainder, er);
        check({tag, ".dz"}, {63'd0, bus.dz}, {63'd0, edz});
        check({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, eovf});
        $display("op %s sgn=%0b a=%h b=%h -> q=%h r=%h dz=%0b ovf=%0b lat=%0d",
                 tag, s, a, b, bus.quotient, bus.remainder, bus.dz, bus.ovf, lat);
        take();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.sgn       = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst.q", bus.quotient, 64'd0);
        check("rst.r", bus.remainder, 64'd0);
        check("rst.dz", {63'd0, bus.dz}, 64'd0);
        check("rst.ovf", {63'd0, bus.ovf}, 64'd0);
        $display("reset applied: in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, N);
`ifdef ALU_DIV_SIGNED_EN
        run_op("s-100/7", 1'b1, M100, 64'd7, M14, M2, 1'b0, 1'b0, N);
        run_op("s100/-7", 1'b1, 64'd100, M7, M14, 64'd2, 1'b0, 1'b0, N);
        run_op("sMIN/-1", 1'b1, MIN_NEG, ONES, MIN_NEG, 64'd0, 1'b0, 1'b1, 0);
`else
        run_op("u-100/7", 1'b1, M100, 64'd7, 64'd2635249153387078788, 64'd0, 1'b0, 1'b0, N);
        run_op("u100/-7", 1'b1, 64'd100, M7, 64'd0, 64'd100, 1'b0, 1'b0, N);
        run_op("uMIN/-1", 1'b1, MIN_NEG, ONES, 64'd0, MIN_NEG, 1'b0, 1'b0, N);
`endif
        run_op("5/0", 1'b0, 64'd5, 64'd0, ONES, 64'd5, 1'b1, 1'b0, 0);

        // Backpressure: hold the result for 10 cycles while a new request is offered.
        send(1'b0, 64'd1000, 64'd7);
        wait_valid(lat);
        check("bp.lat", 64'(lat), 64'(N));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 64'd55;
        bus.divisor  = 64'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp.q", bus.quotient, 64'd142);
            check("bp.r", bus.remainder, 64'd6);
            check("bp.out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp.in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        $display("op bp 1000/7 held 10 cycles -> q=%h r=%h", bus.quotient, bus.remainder);
        bus.in_valid = 1'b0;
        take();
        @(posedge clk);
        #1;
        check("bp.idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("bp.idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Abandon an operation at step 30 of RUN.
        send(1'b0, 64'h1234_5678, 64'd3);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("midrst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst.q", bus.quotient, 64'd0);
        check("midrst.r", bus.remainder, 64'd0);
        check("midrst.dz", {63'd0, bus.dz}, 64'd0);
        check("midrst.ovf", {63'd0, bus.ovf}, 64'd0);
        $display("mid-RUN reset: in_ready=%0b out_valid=%0b q=%h", bus.in_ready, bus.out_valid, bus.quotient);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.no_result", {63'd0, bus.out_valid}, 64'd0);

        run_op("ffff/10", 1'b0, 64'hFFFF, 64'h10, 64'hFFF, 64'hF, 1'b0, 1'b0, N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
